// File: rtl/load_store_initiator.sv
// ---------------------------------------------------------------------------
// load_store_initiator
//
// Turns one pipeline load/store request at a time into a data-memory access.
// Malformed requests (illegal funct3, misaligned half/word) are answered
// with an error response and never reach memory. A stalled access is
// abandoned with an error after TIMEOUT_CYCLES busywait cycles.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_write          1 = store, 0 = load
//   req_funct3         RISC-V funct3 of the access
//   req_addr           byte address
//   req_wdata          store data, right-aligned
//   resp_valid         one-cycle response pulse
//   resp_rdata         load result (0 for stores and errors), held
//   resp_error         error flag qualifying resp_valid, held
//   mem_addr           address to data memory (holds last value)
//   mem_write_data     store data to data memory (holds last value)
//   mem_write_ctrl     {enable, size[1:0]}
//   mem_read_ctrl      {enable, funct3[2:0]}
//   mem_read_data      combinational, already extended read data
//   mem_busywait       memory stall; request is held while high
// ---------------------------------------------------------------------------
module load_store_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_write_ctrl,
    output logic [3:0]  mem_read_ctrl,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busywait
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state_r;
    logic             write_r;
    logic [CNT_W-1:0] cnt_r;
    logic             resp_valid_r;
    logic             resp_error_r;
    logic [31:0]      resp_rdata_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic [2:0]       wctrl_r;
    logic [3:0]       rctrl_r;

    logic             ready_s;
    logic             accept_s;
    logic             bad_s;
    logic             timeout_s;

    // True when the request must be rejected without touching memory.
    function automatic logic req_is_bad(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic bad_f3;
        logic bad_align;
        if (write) begin
            bad_f3 = (f3 > 3'b010);
        end else begin
            bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        case (f3[1:0])
            2'b01:   bad_align = addr_lo[0];
            2'b10:   bad_align = (addr_lo != 2'b00);
            default: bad_align = 1'b0;
        endcase
        return bad_f3 | bad_align;
    endfunction

    // Handshake, request classification and timeout threshold decode.
    always_comb begin
        ready_s   = (state_r == IDLE) && !reset;
        accept_s  = req_valid && ready_s;
        bad_s     = req_is_bad(req_write, req_funct3, req_addr[1:0]);
        timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Main FSM with registered memory controls and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            cnt_r        <= '0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            wctrl_r      <= 3'd0;
            rctrl_r      <= 4'd0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r <= req_write;
                        cnt_r   <= '0;
                        if (bad_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else begin
                            state_r     <= ACCESS;
                            mem_addr_r  <= req_addr;
                            mem_wdata_r <= req_wdata;
                            // Controls are loaded with the transition so they
                            // are valid for exactly the cycles spent in ACCESS.
                            if (req_write) begin
                                wctrl_r <= {1'b1, req_funct3[1:0]};
                                rctrl_r <= 4'd0;
                            end else begin
                                wctrl_r <= 3'd0;
                                rctrl_r <= {1'b1, req_funct3};
                            end
                        end
                    end
                end
                ACCESS: begin
                    // Completion is checked first so a busywait release on
                    // the threshold cycle still succeeds.
                    if (!mem_busywait) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= 1'b0;
                        resp_rdata_r <= write_r ? 32'd0 : mem_read_data;
                        wctrl_r      <= 3'd0;
                        rctrl_r      <= 4'd0;
                    end else if (timeout_s) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= 1'b1;
                        resp_rdata_r <= 32'd0;
                        wctrl_r      <= 3'd0;
                        rctrl_r      <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    wctrl_r <= 3'd0;
                    rctrl_r <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready      = ready_s;
    assign resp_valid     = resp_valid_r;
    assign resp_error     = resp_error_r;
    assign resp_rdata     = resp_rdata_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_wdata_r;
    assign mem_write_ctrl = wctrl_r;
    assign mem_read_ctrl  = rctrl_r;

endmodule
